// File: rtl/divider.sv
// =============================================================================
// Module      : divider
// Description : Iterative radix-2 restoring divider for RV32M div/divu/rem/remu.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [2:0]       funct3,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] F3_DIV = 3'b100;
  localparam logic [2:0] F3_REM = 3'b110;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dvd_q;     // dividend, shifts out MSB-first and fills with quotient bits
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             is_rem_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] div_out_q;
  logic [WIDTH-1:0] quo_out_q;
  logic [WIDTH-1:0] rem_out_q;

  logic             is_signed_d;
  logic             op_valid_d;
  logic             div_zero_d;
  logic             overflow_d;
  logic [WIDTH-1:0] rs1_abs_d;
  logic [WIDTH-1:0] rs2_abs_d;
  logic [WIDTH:0]   rem_shift_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  always_comb begin
    is_signed_d = (funct3 == F3_DIV) || (funct3 == F3_REM);
    op_valid_d  = funct3[2];
    div_zero_d  = (rs2_data == '0);
    overflow_d  = is_signed_d && (rs1_data == MOST_NEG) && (rs2_data == '1);
    rs1_abs_d   = (is_signed_d && rs1_data[WIDTH-1]) ? -rs1_data : rs1_data;
    rs2_abs_d   = (is_signed_d && rs2_data[WIDTH-1]) ? -rs2_data : rs2_data;
    // rem_q < divisor, so the shifted value needs one extra bit and the
    // difference always fits a (WIDTH+1)-bit two's-complement result.
    rem_shift_d = {rem_q, dvd_q[WIDTH-1]};
    trial_d     = rem_shift_d - {1'b0, dvs_q};
    quo_fix_d   = q_neg_q ? -dvd_q : dvd_q;
    rem_fix_d   = r_neg_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      is_rem_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div_out_q <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && op_valid_d) begin
            is_rem_q <= funct3[1];
            busy_q   <= 1'b1;
            count_q  <= CW'(WIDTH - 1);
            dvs_q    <= rs2_abs_d;
            if (div_zero_d) begin
              // Special results are preloaded so FINISH passes them through unchanged.
              dvd_q   <= '1;
              rem_q   <= rs1_data;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
              state_q <= S_FINISH;
            end else if (overflow_d) begin
              dvd_q   <= MOST_NEG;
              rem_q   <= '0;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
              state_q <= S_FINISH;
            end else begin
              dvd_q   <= rs1_abs_d;
              rem_q   <= '0;
              q_neg_q <= is_signed_d & (rs1_data[WIDTH-1] ^ rs2_data[WIDTH-1]);
              r_neg_q <= is_signed_d & rs1_data[WIDTH-1];
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dvd_q   <= {dvd_q[WIDTH-2:0], ~trial_d[WIDTH]};
          rem_q   <= trial_d[WIDTH] ? rem_shift_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
          count_q <= count_q - CW'(1);
          if (count_q == '0) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          quo_out_q <= quo_fix_d;
          rem_out_q <= rem_fix_d;
          div_out_q <= is_rem_q ? rem_fix_d : quo_fix_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign div_out       = div_out_q;
  assign quotient_out  = quo_out_q;
  assign remainder_out = rem_out_q;

endmodule

`default_nettype wire
